// File: rtl/rvfi_retire_serializer_pkg.sv
// rvfi_ser_pkg: shared entry type and lane popcount for the retire serializer
package rvfi_ser_pkg;
  localparam int XLEN = 32;
  localparam int ORDER_W = 64;
  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [XLEN-1:0] pc;
    logic [31:0] insn;
    logic trap;
  } rvfi_ser_entry_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount += 4'(v[i]);
  endfunction
endpackage

// File: rtl/rvfi_retire_serializer_if.sv
// rvfi_retire_serializer_if: in-order retirement stream towards the pipeline shell
interface rvfi_retire_serializer_if #(parameter int XLEN = 32, parameter int ORDER_W = 64);
  logic valid;
  logic ready;
  logic [ORDER_W-1:0] order;
  logic [XLEN-1:0] pc;
  logic [31:0] insn;
  logic trap;
  modport master(output valid, order, pc, insn, trap, input ready);
  modport slave(input valid, order, pc, insn, trap, output ready);
endinterface

// File: rtl/rvfi_lane_compactor.sv
// rvfi_lane_compactor: packs valid lanes densely into slots 0..k-1 in lane order
module rvfi_lane_compactor
  import rvfi_ser_pkg::*;
#(
  parameter int NRET = 2,
  parameter int EW = 129
) (
  input  logic [NRET-1:0] valid,
  input  logic [NRET-1:0][EW-1:0] lanes,
  output logic [NRET-1:0][EW-1:0] slots,
  output logic [3:0] k
);
  always_comb begin
    int n;
    n = 0;
    slots = '0;
    for (int i = 0; i < NRET; i++)
      if (valid[i]) begin
        slots[n] = lanes[i];
        n++;
      end
  end
  assign k = popcount(8'(valid));
endmodule

// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer: buffers up to NRET retirements/cycle and replays them one per cycle with order checking
module rvfi_retire_serializer
  import rvfi_ser_pkg::*;
#(
  parameter int NRET = 2,
  parameter int DEPTH = 16,
  parameter int XLEN = 32,
  parameter int ORDER_W = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic [NRET-1:0] rvfi_valid_i,
  input  logic [NRET*ORDER_W-1:0] rvfi_order_i,
  input  logic [NRET*XLEN-1:0] rvfi_pc_i,
  input  logic [NRET*32-1:0] rvfi_insn_i,
  input  logic [NRET-1:0] rvfi_trap_i,
  rvfi_retire_serializer_if.master out,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic overflow_o,
  output logic order_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ORDER_W + XLEN + 33;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [ORDER_W-1:0] exp_order;
  logic exp_valid, pop, fits, push;
  logic [NRET-1:0][EW-1:0] lanes, slots;
  logic [3:0] k;
  always_comb begin
    lanes = '0;
    for (int i = 0; i < NRET; i++)
      lanes[i] = {rvfi_order_i[i*ORDER_W +: ORDER_W], rvfi_pc_i[i*XLEN +: XLEN],
                  rvfi_insn_i[i*32 +: 32], rvfi_trap_i[i]};
  end
  rvfi_lane_compactor #(.NRET(NRET), .EW(EW)) u_compactor (
    .valid(rvfi_valid_i),
    .lanes(lanes),
    .slots(slots),
    .k(k)
  );
  assign pop = out.valid && out.ready;
  // the slot freed by a same-cycle pop is available to this cycle's push
  assign fits = int'(count) + int'(k) - int'(pop) <= DEPTH;
  assign push = !flush_i && fits && k != 4'd0;
  assign out.valid = count != '0;
  assign {out.order, out.pc, out.insn, out.trap} = out.valid ? mem[rd_ptr] : '0;
  assign count_o = count;
  always_ff @(posedge clk_i)
    for (int s = 0; s < NRET; s++)
      if (push && s < int'(k)) mem[wr_ptr + AW'(s)] <= slots[s];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      exp_order <= '0;
      exp_valid <= 1'b0;
      overflow_o <= 1'b0;
      order_err_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      exp_valid <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (exp_valid && out.order != exp_order) order_err_o <= 1'b1;
        exp_order <= out.order + ORDER_W'(1);
        exp_valid <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(k);
      if (k != 4'd0 && !fits) overflow_o <= 1'b1;
      count <= count - CW'(pop) + (push ? CW'(k) : '0);
    end
endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb_rvfi_retire_serializer: directed scenario tests for the retire serializer
module tb_rvfi_retire_serializer;
  localparam int NRET = 2, DEPTH = 16, XLEN = 32, ORDER_W = 64;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [NRET-1:0] valid = '0, trap = '0;
  logic [NRET*ORDER_W-1:0] order = '0;
  logic [NRET*XLEN-1:0] pc = '0;
  logic [NRET*32-1:0] insn = '0;
  logic [4:0] count;
  logic overflow, order_err;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rvfi_retire_serializer_if #(.XLEN(XLEN), .ORDER_W(ORDER_W)) out_if ();
  rvfi_retire_serializer #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .ORDER_W(ORDER_W)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .flush_i(flush),
    .rvfi_valid_i(valid),
    .rvfi_order_i(order),
    .rvfi_pc_i(pc),
    .rvfi_insn_i(insn),
    .rvfi_trap_i(trap),
    .out(out_if),
    .count_o(count),
    .overflow_o(overflow),
    .order_err_o(order_err)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input int o0, input int o1, input logic t0);
    valid = v;
    order = {64'(o1), 64'(o0)};
    pc = {32'(o1 * 4), 32'(o0 * 4)};
    insn = {32'(o1 + 32'h13), 32'(o0 + 32'h13)};
    trap = {1'b0, t0};
  endtask
  task automatic push_cyc(input logic [1:0] v, input int o0, input int o1);
    drive(v, o0, o1, 1'b0);
    cyc();
    valid = '0;
  endtask
  task automatic do_flush;
    valid = '0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask
  task automatic test_reset;
    out_if.ready = 1'b0;
    cyc();
    checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_if.valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if ({overflow, order_err} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {overflow, order_err}); end
    checks++; if (out_if.order !== 64'd0) begin failures++; $display("FAIL rst_order got=%0d exp=0", out_if.order); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_single;
    out_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, i, 0, i == 2);
      cyc();
      checks++; if (out_if.order !== 64'(i) || count !== 5'd1 || out_if.valid !== 1'b1)
        begin failures++; $display("FAIL single_head%0d got order=%0d count=%0d exp order=%0d count=1", i, out_if.order, count, i); end
    end
    checks++; if (out_if.trap !== 1'b1 || out_if.pc !== 32'd8 || out_if.insn !== 32'h15)
      begin failures++; $display("FAIL single_fields got trap=%b pc=%0d insn=%h exp 1 8 15", out_if.trap, out_if.pc, out_if.insn); end
    valid = '0;
    cyc();
    checks++; if (count !== 5'd0 || out_if.valid !== 1'b0) begin failures++; $display("FAIL single_empty got count=%0d exp=0", count); end
    checks++; if ({overflow, order_err} !== 2'b00) begin failures++; $display("FAIL single_flags got=%b exp=00", {overflow, order_err}); end
  endtask
  task automatic test_dual;
    do_flush();
    out_if.ready = 1'b0;
    push_cyc(2'b10, 0, 5);
    push_cyc(2'b11, 6, 7);
    checks++; if (count !== 5'd3) begin failures++; $display("FAIL dual_count got=%0d exp=3", count); end
    checks++; if (out_if.order !== 64'd5) begin failures++; $display("FAIL dual_head got=%0d exp=5", out_if.order); end
    out_if.ready = 1'b1;
    cyc();
    checks++; if (out_if.order !== 64'd6) begin failures++; $display("FAIL dual_drain6 got=%0d exp=6", out_if.order); end
    cyc();
    checks++; if (out_if.order !== 64'd7) begin failures++; $display("FAIL dual_drain7 got=%0d exp=7", out_if.order); end
    cyc();
    checks++; if (count !== 5'd0 || order_err !== 1'b0) begin failures++; $display("FAIL dual_end got count=%0d err=%b exp 0 0", count, order_err); end
  endtask
  task automatic test_flush;
    out_if.ready = 1'b0;
    push_cyc(2'b11, 1, 2);
    push_cyc(2'b11, 3, 4);
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL flush_pre got=%0d exp=4", count); end
    out_if.ready = 1'b1;
    flush = 1'b1;
    drive(2'b01, 50, 0, 1'b0);
    cyc();
    flush = 1'b0;
    valid = '0;
    checks++; if (count !== 5'd0 || out_if.valid !== 1'b0) begin failures++; $display("FAIL flush_clear got count=%0d valid=%b exp 0 0", count, out_if.valid); end
    out_if.ready = 1'b0;
    push_cyc(2'b01, 9, 0);
    checks++; if (count !== 5'd1 || out_if.order !== 64'd9) begin failures++; $display("FAIL flush_push got count=%0d order=%0d exp 1 9", count, out_if.order); end
    out_if.ready = 1'b1;
    cyc();
    checks++; if (order_err !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL flush_order got err=%b count=%0d exp 0 0", order_err, count); end
  endtask
  task automatic test_overflow;
    int bad;
    do_flush();
    out_if.ready = 1'b0;
    for (int j = 0; j < 8; j++) push_cyc(2'b11, 10 + 2 * j, 11 + 2 * j);
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got count=%0d ovf=%b exp 16 0", count, overflow); end
    out_if.ready = 1'b1;
    push_cyc(2'b01, 26, 0);
    checks++; if (count !== 5'd16 || overflow !== 1'b0 || out_if.order !== 64'd11)
      begin failures++; $display("FAIL ovf_poppush got count=%0d ovf=%b head=%0d exp 16 0 11", count, overflow, out_if.order); end
    out_if.ready = 1'b0;
    push_cyc(2'b01, 27, 0);
    checks++; if (count !== 5'd16 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop got count=%0d ovf=%b exp 16 1", count, overflow); end
    out_if.ready = 1'b1;
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      if (out_if.order !== 64'(11 + j) || out_if.valid !== 1'b1) bad++;
      cyc();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_drain got bad=%0d exp=0", bad); end
    checks++; if (count !== 5'd0 || order_err !== 1'b0) begin failures++; $display("FAIL ovf_end got count=%0d err=%b exp 0 0", count, order_err); end
  endtask
  task automatic test_order_err;
    do_flush();
    out_if.ready = 1'b0;
    push_cyc(2'b01, 3, 0);
    push_cyc(2'b01, 5, 0);
    push_cyc(2'b01, 6, 0);
    out_if.ready = 1'b1;
    cyc();
    checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL oerr_first got=%b exp=0", order_err); end
    cyc();
    checks++; if (order_err !== 1'b1) begin failures++; $display("FAIL oerr_gap got=%b exp=1", order_err); end
    cyc();
    checks++; if (order_err !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL oerr_sticky got err=%b count=%0d exp 1 0", order_err, count); end
  endtask
  task automatic test_async_reset;
    out_if.ready = 1'b0;
    do_flush();
    push_cyc(2'b11, 40, 41);
    push_cyc(2'b11, 42, 43);
    out_if.ready = 1'b1;
    cyc();
    checks++; if (overflow !== 1'b1 || count !== 5'd3) begin failures++; $display("FAIL arst_pre got ovf=%b count=%0d exp 1 3", overflow, count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_if.valid !== 1'b0 || count !== 5'd0 || out_if.order !== 64'd0)
      begin failures++; $display("FAIL arst_out got valid=%b count=%0d order=%0d exp 0 0 0", out_if.valid, count, out_if.order); end
    checks++; if ({overflow, order_err} !== 2'b00) begin failures++; $display("FAIL arst_flags got=%b exp=00", {overflow, order_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    push_cyc(2'b01, 100, 0);
    checks++; if (count !== 5'd1 || out_if.order !== 64'd100) begin failures++; $display("FAIL arst_push got count=%0d order=%0d exp 1 100", count, out_if.order); end
    cyc();
    checks++; if ({overflow, order_err} !== 2'b00 || count !== 5'd0) begin failures++; $display("FAIL arst_after got flags=%b count=%0d exp 00 0", {overflow, order_err}, count); end
  endtask
  initial begin
    out_if.ready = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_flush();
    test_overflow();
    test_order_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
